// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
//   state_t   : sequencing states of the arbiter FSM
//   REQ_*     : requester indices (loader/debug, core data, core fetch)
//   ADDR_W/DATA_W : memory address and data widths
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int REQ_LOADER = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_FETCH  = 2;
  localparam int NUM_REQ    = 3;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;

  // Requester index advanced modulo NUM_REQ.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Winner selection among the three requesters.
//   clk, rst : clock, async active-high reset
//   req      : pending requests
//   take     : the current winner is being accepted this cycle
//   win, any : selected requester index, and whether any request is pending
// ARB_MODE=0 always searches from requester 0; ARB_MODE=1 searches from the
// rotating pointer, which moves past the winner on every accepted request.
module rr_select
  import mem_arb_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [1:0]         win,
  output logic               any
);

  logic [1:0] ptr;
  logic [1:0] cand;

  always_comb begin
    win  = 2'd0;
    any  = 1'b0;
    cand = (ARB_MODE == 0) ? 2'd0 : ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[cand]) begin
        win = cand;
        any = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (take && any) begin
      ptr <= next_idx(win);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between the UART loader (0), core data
// port (1) and core instruction fetch (2). One transaction at a time.
//   clk, reset_n       : clock; reset_n is asynchronous and active HIGH
//   req/req_we         : per-requester request and write flag
//   req_addr/req_wdata : requester i in bits [12i+11:12i]
//   gnt, done          : one-hot single-cycle accept / complete pulses
//   rdata, err         : read data and out-of-range flag, valid with done
//   busy               : arbiter not idle
//   mem_*              : memory control, synchronous read of RD_LAT cycles
//
// state  | meaning
// IDLE   | sample req, latch the winner
// ACCESS | drive memory, pulse gnt
// WAIT   | RD_LAT cycles of read latency, capture data on the last one
// DONE   | pulse done with rdata/err
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_COUNT = 255,
  parameter int RD_LAT    = 1,
  parameter int ARB_MODE  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W+1)'(MEM_COUNT);
  localparam logic [1:0]      LAT_LOAD = 2'(RD_LAT - 1);

  state_t state, next_state;

  logic [1:0]        win, w_idx;
  logic              any, take;
  logic              win_we, win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              lat_we, lat_oor;
  logic [1:0]        wait_cnt;

  assign take      = (state == IDLE) && any;
  assign win_we    = req_we[win];
  assign win_addr  = req_addr[ADDR_W*win +: ADDR_W];
  assign win_wdata = req_wdata[DATA_W*win +: DATA_W];
  assign win_oor   = ({1'b0, win_addr} >= MEM_LIM);

  rr_select #(.ARB_MODE(ARB_MODE)) u_sel (
    .clk  (clk),
    .rst  (reset_n),
    .req  (req),
    .take (take),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any) next_state = ACCESS;
      ACCESS:  next_state = (!lat_we && !lat_oor) ? WAIT : DONE;
      WAIT:    if (wait_cnt == 2'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered: each is loaded on the edge that enters the
  // state in which it must be visible.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      w_idx     <= 2'd0;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
      wait_cnt  <= 2'd0;
    end else begin
      state  <= next_state;
      busy   <= (next_state != IDLE);
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            w_idx     <= win;
            lat_we    <= win_we;
            lat_oor   <= win_oor;
            gnt       <= onehot(win);
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_we    <= win_we && !win_oor;
          end
        end
        ACCESS: begin
          wait_cnt <= LAT_LOAD;
          rdata    <= '0;
          if (next_state == DONE) begin
            done <= onehot(w_idx);
            err  <= lat_oor;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            rdata <= mem_rdata;
            done  <= onehot(w_idx);
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances: dut 0 has RD_LAT=1 and round
// robin, dut 1 has RD_LAT=3 and fixed priority. Only one instance is active
// at a time, so a single set of expectation queues serves both.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [1:0][2:0]  req, req_we, gnt, done;
  logic [1:0][35:0] req_addr, req_wdata;
  logic [1:0][11:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]       err, busy, mem_we;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int dut;
    int idx;
    int cyc;
    int v1;
    int v2;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  exp_t wq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT  = (g == 0) ? 1 : 3;
    localparam int MODE = (g == 0) ? 1 : 0;
    logic [11:0] mem [4096];
    logic [11:0] pipe [3];

    mem_port_arbiter #(.MEM_COUNT(255), .RD_LAT(LAT), .ARB_MODE(MODE)) dut (
      .clk       (clk),
      .reset_n   (rst),
      .req       (req[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .gnt       (gnt[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .err       (err[g]),
      .busy      (busy[g]),
      .mem_addr  (mem_addr[g]),
      .mem_we    (mem_we[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    always @(posedge clk) begin
      if (rst) begin
        mem[12'h010] <= 12'hABC;
        mem[12'h011] <= 12'h123;
        mem[12'h012] <= 12'h456;
      end else if (mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
      end
      pipe[0] <= mem[mem_addr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic chk(input string nm, input int d, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, d, act, expv, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever a dut presents gnt, done or mem_we.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (gnt[d] != 3'b000) begin
        if (gq.size() == 0) chk("gnt_unexpected", d, int'(gnt[d]), 0);
        else begin
          e = gq.pop_front();
          chk("gnt_dut", d, d, e.dut);
          chk("gnt_vec", d, int'(gnt[d]), 1 << e.idx);
          chk("gnt_cycle", d, cyc, e.cyc);
        end
      end
      if (done[d] != 3'b000) begin
        if (dq.size() == 0) chk("done_unexpected", d, int'(done[d]), 0);
        else begin
          e = dq.pop_front();
          chk("done_dut", d, d, e.dut);
          chk("done_vec", d, int'(done[d]), 1 << e.idx);
          chk("done_cycle", d, cyc, e.cyc);
          chk("done_rdata", d, int'(rdata[d]), e.v1);
          chk("done_err", d, int'(err[d]), e.v2);
        end
      end
      if (mem_we[d]) begin
        if (wq.size() == 0) chk("mem_we_unexpected", d, int'(mem_addr[d]), -1);
        else begin
          e = wq.pop_front();
          chk("mem_we_dut", d, d, e.dut);
          chk("mem_we_cycle", d, cyc, e.cyc);
          chk("mem_addr", d, int'(mem_addr[d]), e.v1);
          chk("mem_wdata", d, int'(mem_wdata[d]), e.v2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bit(input int d, input int i, input bit is_done);
    for (int k = 0; k < 40; k++) begin
      step();
      if (!is_done && gnt[d][i]) return;
      if (is_done && done[d][i]) return;
    end
    chk(is_done ? "done_timeout" : "gnt_timeout", d, 0, 1);
  endtask

  // Single request from an idle dut; expectations hand-supplied per vector.
  task automatic txn(input int d, input int i, input bit we, input logic [11:0] addr,
                     input logic [11:0] wd, input logic [11:0] exp_rd,
                     input bit exp_err, input bit exp_memwe);
    int t;
    int lat;
    lat = (d == 0) ? 1 : 3;
    t = cyc;
    gq.push_back('{d, i, t + 1, 0, 0});
    dq.push_back('{d, i, (we || exp_err) ? t + 2 : t + 2 + lat, int'(exp_rd), int'(exp_err)});
    if (exp_memwe) wq.push_back('{d, 0, t + 1, int'(addr), int'(wd)});
    req_we[d][i] = we;
    req_addr[d][12*i +: 12] = addr;
    req_wdata[d][12*i +: 12] = wd;
    req[d][i] = 1'b1;
    wait_bit(d, i, 1'b0);
    req[d][i] = 1'b0;
    wait_bit(d, i, 1'b1);
    step();
  endtask

  // dut 0, round robin from pointer 0, all three write continuously.
  task automatic rr_test();
    int t;
    int n;
    int i;
    t = cyc;
    for (int k = 0; k < 6; k++) begin
      i = k % 3;
      gq.push_back('{0, i, t + 1 + 3*k, 0, 0});
      dq.push_back('{0, i, t + 2 + 3*k, 0, 0});
      wq.push_back('{0, 0, t + 1 + 3*k, 'h040 + i, 'h111 * (i + 1)});
    end
    for (int r = 0; r < 3; r++) begin
      req_addr[0][12*r +: 12]  = 12'(12'h040 + r);
      req_wdata[0][12*r +: 12] = 12'(12'h111 * (r + 1));
    end
    req_we[0] = 3'b111;
    req[0]    = 3'b111;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      step();
      if (gnt[0] != 3'b000) n++;
    end
    req[0] = 3'b000;
    req_we[0] = 3'b000;
    if (n < 6) chk("rr_timeout", 0, n, 6);
    repeat (4) step();
  endtask

  // dut 1, fixed priority, RD_LAT=3: requester 0 wins while it asks, the
  // losers stay pending, grants are 6 cycles apart.
  task automatic fixed_test();
    int t;
    int n;
    int i;
    t = cyc;
    for (int k = 0; k < 5; k++) begin
      i = (k < 3) ? 0 : k - 2;
      gq.push_back('{1, i, t + 1 + 6*k, 0, 0});
      dq.push_back('{1, i, t + 5 + 6*k, (i == 0) ? 'hABC : (i == 1) ? 'h123 : 'h456, 0});
    end
    for (int r = 0; r < 3; r++) req_addr[1][12*r +: 12] = 12'(12'h010 + r);
    req_we[1] = 3'b000;
    req[1]    = 3'b111;
    n = 0;
    for (int k = 0; k < 80 && n < 5; k++) begin
      step();
      if (gnt[1] != 3'b000) begin
        n++;
        if (n == 3) req[1][0] = 1'b0;
        if (n == 4) req[1][1] = 1'b0;
        if (n == 5) req[1][2] = 1'b0;
      end
    end
    req[1] = 3'b000;
    if (n < 5) chk("fixed_timeout", 1, n, 5);
    repeat (6) step();
  endtask

  // Reset asserted while dut 1 waits on a read: no done may follow.
  task automatic reset_test();
    int t;
    t = cyc;
    gq.push_back('{1, 1, t + 1, 0, 0});
    req_we[1][1] = 1'b0;
    req_addr[1][23:12] = 12'h011;
    req[1][1] = 1'b1;
    wait_bit(1, 1, 1'b0);
    req[1][1] = 1'b0;
    step();
    chk("busy_in_wait", 1, int'(busy[1]), 1);
    rst = 1'b1;
    #1;
    chk("abort_done", 1, int'(done[1]), 0);
    chk("abort_busy", 1, int'(busy[1]), 0);
    chk("abort_mem_we", 1, int'(mem_we[1]), 0);
    chk("abort_gnt", 1, int'(gnt[1]), 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_abort_busy", 1, int'(busy[1]), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, int'(gnt[d]), 0);
      chk("rst_done", d, int'(done[d]), 0);
      chk("rst_busy", d, int'(busy[d]), 0);
      chk("rst_mem_we", d, int'(mem_we[d]), 0);
      chk("rst_err", d, int'(err[d]), 0);
      chk("rst_rdata", d, int'(rdata[d]), 0);
      chk("rst_mem_addr", d, int'(mem_addr[d]), 0);
      chk("rst_mem_wdata", d, int'(mem_wdata[d]), 0);
    end
    rst = 1'b0;
    step();

    rr_test();
    txn(0, 2, 1'b0, 12'h010, 12'h000, 12'hABC, 1'b0, 1'b0);
    txn(0, 1, 1'b1, 12'h020, 12'h5A5, 12'h000, 1'b0, 1'b1);
    txn(0, 0, 1'b0, 12'h020, 12'h000, 12'h5A5, 1'b0, 1'b0);
    txn(0, 0, 1'b1, 12'h0FF, 12'h777, 12'h000, 1'b1, 1'b0);
    txn(0, 1, 1'b1, 12'h0FE, 12'h321, 12'h000, 1'b0, 1'b1);
    txn(0, 2, 1'b0, 12'h0FE, 12'h000, 12'h321, 1'b0, 1'b0);
    txn(0, 2, 1'b0, 12'h0FF, 12'h000, 12'h000, 1'b1, 1'b0);

    txn(1, 2, 1'b0, 12'h010, 12'h000, 12'hABC, 1'b0, 1'b0);
    txn(1, 1, 1'b1, 12'h0FE, 12'h0C3, 12'h000, 1'b0, 1'b1);
    txn(1, 0, 1'b0, 12'h0FE, 12'h000, 12'h0C3, 1'b0, 1'b0);
    txn(1, 1, 1'b0, 12'hFFF, 12'h000, 12'h000, 1'b1, 1'b0);
    fixed_test();

    reset_test();
    txn(1, 0, 1'b0, 12'h010, 12'h000, 12'hABC, 1'b0, 1'b0);
    txn(0, 0, 1'b0, 12'h011, 12'h000, 12'h123, 1'b0, 1'b0);

    repeat (4) step();
    chk("gnt_queue_left", 0, gq.size(), 0);
    chk("done_queue_left", 0, dq.size(), 0);
    chk("mem_we_queue_left", 0, wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
